// File: rtl/jk_excitation_sequencer.sv
// JK excitation sequencer: drives J/K/enable of an external negedge JK bank
// until its readback matches a captured target, retrying up to MAX_RETRY
// times, and reports the result through a start/busy/done/error handshake.

// Per-bit excitation: the bit is held unless it differs from the target.
// When it differs, set/reset mode drives it straight to the target value
// and toggle mode flips it.
module jk_exc_lane (
  input  logic q,
  input  logic t,
  input  logic md,
  output logic jn,
  output logic kn
);
  logic diff;

  // Combinational J/K for one bit
  always_comb begin
    diff = q ^ t;
    jn   = diff & (md | t);
    kn   = diff & (md | ~t);
  end
endmodule

module jk_excitation_sequencer #(
  parameter int W         = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] target,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         ff_enable,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [3:0]   attempts
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_APPLY = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]   state;
  logic [W-1:0] tgt;
  logic         md;
  logic [3:0]   retry;
  logic [W-1:0] j_nxt, k_nxt;
  logic         match;

  assign match = (q_fb == tgt);

  // One excitation lane per bank bit
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_lane
      jk_exc_lane u_lane (
        .q  (q_fb[gi]),
        .t  (tgt[gi]),
        .md (md),
        .jn (j_nxt[gi]),
        .kn (k_nxt[gi])
      );
    end
  endgenerate

  // Sequencer FSM; every output is registered. J/K/enable default to 0 and
  // are only loaded on the edge that enters APPLY, so the bank sees a single
  // enable cycle per attempt, computed from q_fb sampled on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tgt       <= '0;
      md        <= 1'b0;
      retry     <= '0;
      j         <= '0;
      k         <= '0;
      ff_enable <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      attempts  <= '0;
    end else begin
      j         <= '0;
      k         <= '0;
      ff_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            tgt      <= target;
            md       <= mode;
            retry    <= '0;
            attempts <= '0;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (match) begin
            done  <= 1'b1;
            error <= 1'b0;
            state <= S_FIN;
          end else begin
            j         <= j_nxt;
            k         <= k_nxt;
            ff_enable <= 1'b1;
            attempts  <= attempts + 4'd1;
            state     <= S_APPLY;
          end
        end
        S_APPLY: state <= S_CHECK;
        S_CHECK: begin
          if (match) begin
            done  <= 1'b1;
            error <= 1'b0;
            state <= S_FIN;
          end else if (retry < 4'(MAX_RETRY)) begin
            retry     <= retry + 4'd1;
            j         <= j_nxt;
            k         <= k_nxt;
            ff_enable <= 1'b1;
            attempts  <= attempts + 4'd1;
            state     <= S_APPLY;
          end else begin
            done  <= 1'b1;
            error <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          error <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Bench for jk_excitation_sequencer: negedge JK bank model with optional
// stuck-at-0 bits, directed and randomized operations against a
// result-level reference (attempts, error, latency, final bank value).
module tb_jk_excitation_sequencer;
  localparam int W  = 4;
  localparam int MR = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] q_fb;
  logic [W-1:0] j, k;
  logic         ff_enable, busy, done, error;
  logic [3:0]   attempts;

  logic [W-1:0] bank = '0;
  logic [W-1:0] stuck = '0;
  logic [W-1:0] ref_tgt = '0;
  logic         ref_md = 1'b0;
  int           applies = 0;
  int           passes = 0;
  int           total = 0;

  assign q_fb = bank;

  always #5 clk = ~clk;

  jk_excitation_sequencer #(.W(W), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .target(target),
    .q_fb(q_fb), .j(j), .k(k), .ff_enable(ff_enable), .busy(busy),
    .done(done), .error(error), .attempts(attempts)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected excitation from the bank value and the originally requested op
  function automatic logic [W-1:0] exp_j(input logic [W-1:0] q);
    logic [W-1:0] d;
    d = q ^ ref_tgt;
    return ref_md ? d : (ref_tgt & d);
  endfunction

  function automatic logic [W-1:0] exp_k(input logic [W-1:0] q);
    logic [W-1:0] d;
    d = q ^ ref_tgt;
    return ref_md ? d : (~ref_tgt & d);
  endfunction

  // JK bank: updates on negedge when enabled; stuck bits read back as 0
  always @(negedge clk) begin
    logic [W-1:0] nb;
    if (ff_enable === 1'b1) begin
      chk("apply_j", 32'(j), 32'(exp_j(bank)));
      chk("apply_k", 32'(k), 32'(exp_k(bank)));
      for (int i = 0; i < W; i++)
        case ({j[i], k[i]})
          2'b10:   nb[i] = 1'b1;
          2'b01:   nb[i] = 1'b0;
          2'b11:   nb[i] = ~bank[i];
          default: nb[i] = bank[i];
        endcase
      bank = nb & ~stuck;
      applies++;
    end else begin
      chk("quiet_jk", 32'({j, k}), 32'd0);
    end
  end

  // One full operation; called just after a posedge with the DUT idle
  task automatic run_op(input logic [W-1:0] b0, input logic [W-1:0] st,
                        input logic [W-1:0] tg, input logic m, input bit disturb);
    logic [W-1:0] cur;
    int a, n;
    bit seen;
    stuck   = st;
    bank    = b0 & ~st;
    ref_tgt = tg;
    ref_md  = m;
    // Each attempt drives every non-stuck bit to the target
    cur = bank;
    a   = 0;
    while (cur != tg && a <= MR) begin
      cur = tg & ~st;
      a++;
    end
    applies = 0;
    @(negedge clk);
    start  = 1'b1;
    target = tg;
    mode   = m;
    @(posedge clk); #1;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (disturb) begin
      target = W'($urandom);
      mode   = 1'($urandom);
    end else begin
      start = 1'b0;
    end
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (disturb) target = W'($urandom);
      if (done === 1'b1) seen = 1;
    end
    chk("latency", 32'(n), 32'(1 + 2 * a));
    chk("error", 32'(error), 32'(cur != tg));
    chk("attempts", 32'(attempts), 32'(a));
    chk("busy_fin", 32'(busy), 32'd1);
    chk("bank_final", 32'(bank), 32'(cur));
    chk("apply_pulses", 32'(applies), 32'(a));
    @(posedge clk); #1;
    chk("idle_flags", 32'({busy, done, error}), 32'd0);
    chk("attempts_held", 32'(attempts), 32'(a));
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_outs", 32'({j, k, ff_enable, busy, done, error, attempts}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    run_op(4'b0000, 4'b0000, 4'b1010, 1'b0, 0);  // set/reset
    run_op(4'b1100, 4'b0000, 4'b0110, 1'b1, 0);  // toggle
    run_op(4'b0101, 4'b0000, 4'b0101, 1'b0, 0);  // already matching
    run_op(4'b0000, 4'b0001, 4'b0001, 1'b0, 0);  // stuck bit, exhaust retries
    run_op(4'b0011, 4'b0000, 4'b1100, 1'b1, 1);  // start/target churn while busy

    // Reset during CHECK aborts with no done
    stuck = '0; bank = 4'b0000; ref_tgt = 4'b0011; ref_md = 1'b0;
    @(negedge clk);
    start = 1'b1; target = 4'b0011; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_outs", 32'({j, k, ff_enable, busy, done, error, attempts}), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'({busy, done}), 32'd0);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_op(4'b1111, 4'b0000, 4'b0001, 1'b0, 0);

    // Randomized operations
    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] st;
      st = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      run_op(W'($urandom), st, W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
